uart_receiver: RTL and testbench
================================

Name: uart_receiver

Overview:
- On-chip UART receive path of the Riscv151 SoC. Deserialises the FPGA_SERIAL_RX line (8N1, LSB first) into bytes and offers them to the memory-mapped I/O logic through a ready/valid interface.
- The BIOS echo loop and the lw/sw/jal command parser consume its output.
- Flags framing errors and overruns so software can detect lost input.

Parameters:
- CLOCK_FREQ, 50_000_000, core clock frequency in Hz.
- BAUD_RATE, 115_200, serial bit rate.
- Derived localparam SYMBOL_EDGE_TIME = CLOCK_FREQ/BAUD_RATE (434 at defaults). This is the number of cycles per bit.
- Derived localparam SAMPLE_TIME = SYMBOL_EDGE_TIME/2 (217 at defaults). This is the mid-bit offset.
- Derived localparam CNT_W = $clog2(SYMBOL_EDGE_TIME).

Ports:
- clk  input  1  core clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- serial_in  input  1  asynchronous RX line; idles high.
- data_out  output  8  received byte.
- data_out_valid  output  1  data_out holds an unconsumed byte.
- data_out_ready  input  1  consumer accepts the byte this cycle.
- framing_error  output  1  one-cycle pulse when a stop bit is sampled low.
- overrun  output  1  sticky; a complete byte was dropped because the holding register was full.
- clear_overrun  input  1  synchronous clear of overrun.
- busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset values: data_out=0, data_out_valid=0, framing_error=0, overrun=0, busy=0, FSM=IDLE, bit counter=0, cycle counter=0.
- Reset also forces both synchroniser flops and the previous-sample register to 1, and clears the `armed` flag.
- Reset mid-frame abandons the partial byte. A byte already held in data_out is also discarded.
- Synchroniser: serial_in passes through 2 flops to give rx_s. All decisions use rx_s, which adds 2 cycles of latency.
- `armed` sets on the first cycle rx_s==1 after reset. No start is detected while `armed` is 0, so a line held low through reset is never taken as a start.
- IDLE: a falling edge (previous rx_s=1, current rx_s=0, armed=1) clears the cycle counter and moves to START.
- START: at counter==SAMPLE_TIME-1, sample rx_s.
  - If 1 (glitch), return to IDLE.
  - If 0, clear the counter, set the bit index to 0, and go to DATA.
- DATA: at counter==SYMBOL_EDGE_TIME-1, sample rx_s into shift bit[index] (LSB first) and restart the counter. After index 7, go to STOP.
- STOP: at counter==SYMBOL_EDGE_TIME-1, sample rx_s.
  - If 1, the frame is good: deliver the byte (see handshake). Return to IDLE.
  - If 0, pulse framing_error for one cycle and discard the byte. Return to IDLE.
  - After a framing error, IDLE still requires a high-to-low edge before the next start.
- Handshake:
  - A transfer occurs on a cycle where data_out_valid && data_out_ready; the next cycle valid=0, unless a byte is delivered the same cycle.
  - data_out and data_out_valid register on the cycle after the stop-bit sample.
  - data_out must stay stable while valid=1.
  - Delivery with valid=0, or with valid=1 && ready=1 in the same cycle: load data_out and set valid=1. Overrun is unaffected.
  - Delivery with valid=1 && ready=0: keep the old byte, set overrun=1, and drop the new byte.
  - If clear_overrun and a new overrun occur in the same cycle, overrun ends at 1 (set wins).
- Latency: from the start-bit falling edge at serial_in to data_out_valid=1 is 2 + SAMPLE_TIME + 9*SYMBOL_EDGE_TIME + 1 cycles, ±1 for edge alignment. At defaults this is 4126 cycles.
- After the STOP sample the FSM is in IDLE with roughly half a stop bit remaining. It accepts back-to-back frames with no idle gap.
- Counters never exceed SYMBOL_EDGE_TIME-1, so there is no wrap-around.

Test Plan:
- Reset release with serial_in=1, then send 0x61 at 115200 baud with ready=1 → data_out=0x61 and valid high for exactly 1 cycle, about 4126 cycles after the start edge; framing_error=0, overrun=0.
- Send "abcd " (0x61 0x62 0x63 0x64 0x20) back-to-back with no gap, ready held 1 → five valid pulses in order, each about 4340 cycles apart, no errors.
- Hold ready=0 and send 0x35 then 0x31 → data_out stays 0x35 and valid stays 1; overrun rises one cycle after the second stop sample. Then assert ready for 1 cycle → valid falls; pulse clear_overrun → overrun=0.
- Send a frame 0x3e with the stop bit driven 0 → framing_error high for exactly 1 cycle, valid stays 0. Then release the line high and send 0x20 → data_out=0x20 received cleanly.
- Drive a 100-cycle low glitch on an idle line → FSM returns to IDLE after the START check, no valid, no framing_error, busy high for about 217 cycles only.
- Assert rst for 3 cycles mid-way through the DATA bits of 0x73 → all outputs return to reset values, no byte is delivered, and a subsequent 0x77 frame is received correctly. Hold serial_in=0 across a reset release → no start is detected until the line has been seen high.

Source files
------------

// File: rtl/uart_receiver.sv
// Riscv151 UART receive path: 8N1 deserialiser with a ready/valid byte output,
// a one-cycle framing-error pulse and a sticky overrun flag.
module uart_receiver #(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int BAUD_RATE  = 115_200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       serial_in,
  output logic [7:0] data_out,
  output logic       data_out_valid,
  input  logic       data_out_ready,
  output logic       framing_error,
  output logic       overrun,
  input  logic       clear_overrun,
  output logic       busy
);
  localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
  localparam int SAMPLE_TIME      = SYMBOL_EDGE_TIME / 2;
  localparam int CNT_W            = $clog2(SYMBOL_EDGE_TIME);
  localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLE_TIME - 1);
  localparam logic [CNT_W-1:0] SYMBOL_LAST = CNT_W'(SYMBOL_EDGE_TIME - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state;
  logic             rx_p0, rx_p1, rx_prev;
  logic             vld_p0, vld_p1;
  logic             armed;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic             rx_s;
  logic             start_edge;

  assign rx_s       = rx_p1;
  assign start_edge = armed && rx_prev && !rx_s;

  // Stage p0/p1: two-flop synchroniser. The vld_pN bits mark when rx_p1 holds a
  // real line sample rather than the reset-forced 1, so a line held low through
  // reset cannot arm the start detector.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_p0   <= 1'b1;
      rx_p1   <= 1'b1;
      rx_prev <= 1'b1;
      vld_p0  <= 1'b0;
      vld_p1  <= 1'b0;
      armed   <= 1'b0;
    end else begin
      rx_p0   <= serial_in;
      rx_p1   <= rx_p0;
      rx_prev <= rx_p1;
      vld_p0  <= 1'b1;
      vld_p1  <= vld_p0;
      if (vld_p1 && rx_s) armed <= 1'b1;
    end
  end

  // Frame FSM and output holding register. Later assignments in this block
  // override the default handshake/pulse updates made at its top.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= '0;
      bit_idx        <= '0;
      shift          <= '0;
      data_out       <= '0;
      data_out_valid <= 1'b0;
      framing_error  <= 1'b0;
      overrun        <= 1'b0;
      busy           <= 1'b0;
    end else begin
      framing_error <= 1'b0;
      if (clear_overrun) overrun <= 1'b0;
      if (data_out_valid && data_out_ready) data_out_valid <= 1'b0;

      case (state)
        IDLE: begin
          cnt <= '0;
          if (start_edge) begin
            state <= START;
            busy  <= 1'b1;
          end
        end
        START: begin
          if (cnt == SAMPLE_LAST) begin
            cnt <= '0;
            if (rx_s) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              bit_idx <= '0;
              state   <= DATA;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DATA: begin
          if (cnt == SYMBOL_LAST) begin
            cnt            <= '0;
            shift[bit_idx] <= rx_s;
            bit_idx        <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= STOP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        STOP: begin
          if (cnt == SYMBOL_LAST) begin
            cnt   <= '0;
            state <= IDLE;
            busy  <= 1'b0;
            if (!rx_s) begin
              framing_error <= 1'b1;
            end else if (!data_out_valid || data_out_ready) begin
              data_out       <= shift;
              data_out_valid <= 1'b1;
            end else begin
              overrun <= 1'b1;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver: a table of frames with expected results, hand-written
// corner sequences, and random frames checked against a frame-level model.
module tb_uart_receiver;
  localparam int CLOCK_FREQ = 50_000_000;
  localparam int BAUD_RATE  = 115_200;
  localparam int BIT_CYC    = CLOCK_FREQ / BAUD_RATE;
  localparam int LATENCY    = 2 + BIT_CYC / 2 + 9 * BIT_CYC + 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       serial_in;
  logic [7:0] data_out;
  logic       data_out_valid;
  logic       data_out_ready;
  logic       framing_error;
  logic       overrun;
  logic       clear_overrun;
  logic       busy;

  uart_receiver #(.CLOCK_FREQ(CLOCK_FREQ), .BAUD_RATE(BAUD_RATE)) dut (
    .clk(clk), .rst(rst), .serial_in(serial_in),
    .data_out(data_out), .data_out_valid(data_out_valid),
    .data_out_ready(data_out_ready), .framing_error(framing_error),
    .overrun(overrun), .clear_overrun(clear_overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observer: records every transfer and counts pulse/level cycles.
  logic [7:0] xfer_q[$];
  int   rise_cnt = 0, last_rise = 0, vld_cyc = 0, ferr_cnt = 0, busy_cyc = 0;
  logic prev_valid = 1'b0;
  always @(negedge clk) begin
    if (data_out_valid && data_out_ready) xfer_q.push_back(data_out);
    if (data_out_valid && !prev_valid) begin
      rise_cnt++;
      last_rise = cyc;
    end
    if (data_out_valid) vld_cyc++;
    if (framing_error) ferr_cnt++;
    if (busy) busy_cyc++;
    prev_valid = data_out_valid;
  end

  int checks = 0, errors = 0;
  int start_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_near(input string name, input int act, input int exp, input int tol);
    checks++;
    if (act < exp - tol || act > exp + tol) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d +/- %0d", name, act, exp, tol);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_data_out"}, 32'(data_out), 32'h0);
    check({tag, "_valid"}, 32'(data_out_valid), 32'h0);
    check({tag, "_ferr"}, 32'(framing_error), 32'h0);
    check({tag, "_overrun"}, 32'(overrun), 32'h0);
    check({tag, "_busy"}, 32'(busy), 32'h0);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_bit(input logic v);
    serial_in = v;
    tick(BIT_CYC);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input int gap);
    serial_in = 1'b1;
    tick(gap);
    start_cyc = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop);
  endtask

  task automatic send_and_expect(input string tag, input logic [7:0] b);
    int xq0;
    xq0 = xfer_q.size();
    send_frame(b, 1'b1, 20);
    check({tag, "_cnt"}, xfer_q.size() - xq0, 32'd1);
    if (xfer_q.size() > xq0) check({tag, "_data"}, 32'(xfer_q[xq0]), 32'(b));
  endtask

  typedef struct packed {
    logic [7:0] data;
    logic       stop;
    logic       ready;
    logic [7:0] gap;
    logic       exp_xfer;
    logic [7:0] exp_data;
    logic       exp_valid;
    logic       exp_ovr;
    logic       exp_ferr;
    logic       exp_rise;
  } vec_t;
  vec_t vecs[10];

  task automatic apply_vec(input int k);
    vec_t  v;
    int    xq0, rise0, vc0, fe0;
    string tag;
    v     = vecs[k];
    tag   = $sformatf("v%0d", k);
    xq0   = xfer_q.size();
    rise0 = rise_cnt;
    vc0   = vld_cyc;
    fe0   = ferr_cnt;
    data_out_ready = v.ready;
    send_frame(v.data, v.stop, int'(v.gap));
    check({tag, "_xfer_cnt"}, xfer_q.size() - xq0, 32'(v.exp_xfer));
    if (v.exp_xfer && xfer_q.size() > xq0)
      check({tag, "_xfer_data"}, 32'(xfer_q[xq0]), 32'(v.exp_data));
    check({tag, "_rise"}, rise_cnt - rise0, 32'(v.exp_rise));
    if (v.exp_rise) check_near({tag, "_latency"}, last_rise - start_cyc, LATENCY, 1);
    if (v.ready) check({tag, "_valid_cycles"}, vld_cyc - vc0, 32'(v.exp_xfer));
    check({tag, "_valid"}, 32'(data_out_valid), 32'(v.exp_valid));
    check({tag, "_data_out"}, 32'(data_out), 32'(v.exp_data));
    check({tag, "_overrun"}, 32'(overrun), 32'(v.exp_ovr));
    check({tag, "_ferr"}, ferr_cnt - fe0, 32'(v.exp_ferr));
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  logic [7:0] m_exp[$];
  logic       m_valid, m_ovr;
  logic [7:0] m_data;
  logic [7:0] rb, pb;
  logic       rstop, rrdy, prev_stop;
  int         rgap, xq0, rise0, fe0, b0;

  initial begin
    //          data   stop  rdy   gap    xfer  data   vld   ovr   ferr  rise
    vecs[0] = '{8'h61, 1'b1, 1'b1, 8'd20, 1'b1, 8'h61, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{8'h61, 1'b1, 1'b1, 8'd20, 1'b1, 8'h61, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{8'h62, 1'b1, 1'b1, 8'd0,  1'b1, 8'h62, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{8'h63, 1'b1, 1'b1, 8'd0,  1'b1, 8'h63, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{8'h64, 1'b1, 1'b1, 8'd0,  1'b1, 8'h64, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{8'h20, 1'b1, 1'b1, 8'd0,  1'b1, 8'h20, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[6] = '{8'h35, 1'b1, 1'b0, 8'd20, 1'b0, 8'h35, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[7] = '{8'h31, 1'b1, 1'b0, 8'd0,  1'b0, 8'h35, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[8] = '{8'h3e, 1'b0, 1'b1, 8'd20, 1'b0, 8'h35, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[9] = '{8'h20, 1'b1, 1'b1, 8'd30, 1'b1, 8'h20, 1'b0, 1'b0, 1'b0, 1'b1};

    serial_in      = 1'b1;
    rst            = 1'b1;
    data_out_ready = 1'b0;
    clear_overrun  = 1'b0;
    tick(3);
    check_reset_state("reset");
    rst = 1'b0;
    tick(10);
    check_reset_state("idle");

    for (int k = 0; k < 8; k++) apply_vec(k);

    // Drain the held byte, then clear the sticky overrun.
    xq0 = xfer_q.size();
    data_out_ready = 1'b1;
    tick(1);
    data_out_ready = 1'b0;
    check("drain_valid", 32'(data_out_valid), 32'h0);
    check("drain_cnt", xfer_q.size() - xq0, 32'd1);
    if (xfer_q.size() > xq0) check("drain_data", 32'(xfer_q[xq0]), 32'h35);
    check("ovr_sticky", 32'(overrun), 32'h1);
    clear_overrun = 1'b1;
    tick(1);
    clear_overrun = 1'b0;
    check("ovr_cleared", 32'(overrun), 32'h0);

    for (int k = 8; k < 10; k++) apply_vec(k);

    // Short low glitch on an idle line.
    b0 = busy_cyc; rise0 = rise_cnt; fe0 = ferr_cnt;
    serial_in = 1'b0;
    tick(100);
    serial_in = 1'b1;
    tick(600);
    check_near("glitch_busy_cycles", busy_cyc - b0, BIT_CYC / 2, 2);
    check("glitch_rise", rise_cnt - rise0, 32'd0);
    check("glitch_ferr", ferr_cnt - fe0, 32'd0);
    check("glitch_busy", 32'(busy), 32'h0);

    // Held byte, then reset in the middle of the next frame's data bits.
    data_out_ready = 1'b0;
    send_frame(8'h55, 1'b1, 20);
    check("held_valid", 32'(data_out_valid), 32'h1);
    check("held_data", 32'(data_out), 32'h55);
    pb = 8'h73;
    serial_in = 1'b1;
    tick(20);
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(pb[i]);
    serial_in = pb[4];
    tick(BIT_CYC / 2);
    check("mid_busy", 32'(busy), 32'h1);
    rise0 = rise_cnt; fe0 = ferr_cnt; xq0 = xfer_q.size();
    rst = 1'b1;
    #1;
    check_reset_state("mid_rst_async");
    tick(3);
    check_reset_state("mid_rst_hold");
    rst = 1'b0;
    serial_in = 1'b1;
    tick(1000);
    check("mid_no_rise", rise_cnt - rise0, 32'd0);
    check("mid_no_ferr", ferr_cnt - fe0, 32'd0);
    check("mid_no_xfer", xfer_q.size() - xq0, 32'd0);
    check("mid_idle", 32'(busy), 32'h0);
    data_out_ready = 1'b1;
    send_and_expect("mid_after", 8'h77);

    // Line held low across reset release must not look like a start.
    serial_in = 1'b0;
    tick(5);
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    b0 = busy_cyc; rise0 = rise_cnt; fe0 = ferr_cnt;
    tick(2000);
    check("low_rst_busy", busy_cyc - b0, 32'd0);
    check("low_rst_rise", rise_cnt - rise0, 32'd0);
    check("low_rst_ferr", ferr_cnt - fe0, 32'd0);
    send_and_expect("low_rst_rx", 8'h4b);

    // Random frames against a frame-level model of the holding register.
    m_valid = 1'b0; m_ovr = 1'b0; m_data = 8'h4b; prev_stop = 1'b1;
    for (int n = 0; n < 4; n++) begin
      rb    = 8'($urandom_range(0, 255));
      rstop = ($urandom_range(0, 3) != 0);
      rrdy  = 1'($urandom_range(0, 1));
      rgap  = int'($urandom_range(0, 30));
      if (!prev_stop && rgap < 2) rgap = 2;
      m_exp.delete();
      if (rrdy && m_valid) begin
        m_exp.push_back(m_data);
        m_valid = 1'b0;
      end
      if (rstop) begin
        if (rrdy) begin
          m_exp.push_back(rb);
          m_data = rb;
        end else if (!m_valid) begin
          m_valid = 1'b1;
          m_data  = rb;
        end else begin
          m_ovr = 1'b1;
        end
      end
      xq0 = xfer_q.size(); fe0 = ferr_cnt;
      data_out_ready = rrdy;
      send_frame(rb, rstop, rgap);
      check($sformatf("rnd%0d_xfer_cnt", n), xfer_q.size() - xq0, m_exp.size());
      for (int j = 0; j < m_exp.size(); j++)
        if (xq0 + j < xfer_q.size())
          check($sformatf("rnd%0d_xfer%0d", n, j), 32'(xfer_q[xq0 + j]), 32'(m_exp[j]));
      check($sformatf("rnd%0d_ferr", n), ferr_cnt - fe0, 32'(!rstop));
      check($sformatf("rnd%0d_valid", n), 32'(data_out_valid), 32'(m_valid));
      check($sformatf("rnd%0d_data_out", n), 32'(data_out), 32'(m_data));
      check($sformatf("rnd%0d_overrun", n), 32'(overrun), 32'(m_ovr));
      prev_stop = rstop;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
